zero_flag_pipe: RTL and testbench

Parametrised, pipelined successor to the CPU's combinational zero detector. Reduces a WIDTH-bit ALU result through a registered OR tree of fan-in 4, producing a per-operation zero result for CBZ-style branches. It also maintains the architectural NZCV flag register, updated only by flag-setting operations. It sits between the ALU output and the branch/flag logic of the execute stage, with a valid/flush interface so in-flight operations can be killed on a pipeline flush.

---
 rtl/zero_flag_pipe.sv | 139 +++++++++++++
 tb/tb_zero_flag_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/zero_flag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : zero_flag_pipe
// Purpose  : Pipelined fan-in-4 OR-tree zero detector with NZCV flag register
//            and valid/flush control for the execute stage.
// Revision : 1.0
// ============================================================================
module zero_flag_pipe #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_carry,
    input  logic             in_overflow,
    input  logic             in_set_flags,
    input  logic             flush,
    output logic             out_valid,
    output logic             result_zero,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy
);

    function automatic int calc_levels(input int w);
        int n;
        int c;
        n = 1;
        c = 0;
        while (n < w) begin
            n = n * 4;
            c = c + 1;
        end
        return c;
    endfunction

    // Width of the vector feeding level k (level 0 is the raw ALU result).
    function automatic int level_in_width(input int k);
        int w;
        w = WIDTH;
        for (int i = 0; i < k; i++) begin
            w = (w + 3) / 4;
        end
        return w;
    endfunction

    localparam int LEVELS = calc_levels(WIDTH);

    logic              w_final_or;
    logic [LEVELS-1:0] r_valid;
    logic [LEVELS-1:0] r_n;
    logic [LEVELS-1:0] r_c;
    logic [LEVELS-1:0] r_v;
    logic [LEVELS-1:0] r_sf;
    logic [3:0]        r_nzcv;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int W_IN  = level_in_width(k);
        localparam int W_OUT = level_in_width(k + 1);

        logic [W_IN-1:0]    w_src;
        logic [4*W_OUT-1:0] w_pad;
        logic [W_OUT-1:0]   w_or;
        logic [W_OUT-1:0]   r_or;

        if (k == 0) begin : g_src_first
            assign w_src = in_data;
        end else begin : g_src_next
            assign w_src = g_level[k-1].r_or;
        end

        // Zero padding makes the short top group behave like a full group.
        always_comb begin
            w_pad            = '0;
            w_pad[W_IN-1:0]  = w_src;
            for (int j = 0; j < W_OUT; j++) begin
                w_or[j] = |w_pad[4*j +: 4];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_or <= '0;
            end else begin
                r_or <= w_or;
            end
        end

        if (k == LEVELS - 1) begin : g_last
            assign w_final_or = r_or[0];
        end
    end

    assign out_valid   = r_valid[LEVELS-1];
    assign result_zero = r_valid[LEVELS-1] & ~w_final_or;
    assign busy        = |r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_n     <= '0;
            r_c     <= '0;
            r_v     <= '0;
            r_sf    <= '0;
        end else begin
            r_valid[0] <= in_valid & ~flush;
            r_n[0]     <= in_data[WIDTH-1];
            r_c[0]     <= in_carry;
            r_v[0]     <= in_overflow;
            r_sf[0]    <= in_set_flags;
            for (int k = 1; k < LEVELS; k++) begin
                r_valid[k] <= r_valid[k-1] & ~flush;
                r_n[k]     <= r_n[k-1];
                r_c[k]     <= r_c[k-1];
                r_v[k]     <= r_v[k-1];
                r_sf[k]    <= r_sf[k-1];
            end
        end
    end

    // The completing operation still retires on a flush edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nzcv <= 4'b0000;
        end else if (r_valid[LEVELS-1] && r_sf[LEVELS-1]) begin
            r_nzcv <= {r_n[LEVELS-1], result_zero, r_c[LEVELS-1], r_v[LEVELS-1]};
        end
    end

    assign flag_n = r_nzcv[3];
    assign flag_z = r_nzcv[2];
    assign flag_c = r_nzcv[1];
    assign flag_v = r_nzcv[0];

endmodule
`default_nettype wire

// File: tb/tb_zero_flag_pipe.sv
`default_nettype none
// Testbench for zero_flag_pipe: directed scenarios plus random stream against
// a queue-based reference model (WIDTH=64), and a directed WIDTH=13 instance.
module tb_zero_flag_pipe;
    localparam int LV = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_carry = 1'b0, in_overflow = 1'b0;
    logic        in_set_flags = 1'b0, flush = 1'b0;
    logic [63:0] in_data = '0;
    logic        out_valid, result_zero, flag_n, flag_z, flag_c, flag_v, busy;

    logic        v13 = 1'b0, sf13 = 1'b0;
    logic [12:0] d13 = '0;
    logic        ov13, rz13, n13, z13, c13, vv13, busy13;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit zero;
        bit n;
        bit c;
        bit v;
        bit sf;
        int stage;
    } op_t;

    op_t      pipe[$];
    bit [3:0] m_flags = 4'b0000;

    always #5 clk = ~clk;

    zero_flag_pipe #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_carry(in_carry), .in_overflow(in_overflow), .in_set_flags(in_set_flags),
        .flush(flush), .out_valid(out_valid), .result_zero(result_zero),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
        .busy(busy)
    );

    zero_flag_pipe #(.WIDTH(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .in_valid(v13), .in_data(d13),
        .in_carry(1'b0), .in_overflow(1'b0), .in_set_flags(sf13),
        .flush(1'b0), .out_valid(ov13), .result_zero(rz13),
        .flag_n(n13), .flag_z(z13), .flag_c(c13), .flag_v(vv13),
        .busy(busy13)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit exp_ov;
        exp_ov = (pipe.size() > 0) && (pipe[0].stage == LV);
        check_eq("out_valid", out_valid, exp_ov);
        if (exp_ov) check_eq("result_zero", result_zero, pipe[0].zero);
        check_eq("nzcv", {flag_n, flag_z, flag_c, flag_v}, m_flags);
        check_eq("busy", busy, pipe.size() != 0);
    endtask

    // Reference: ops age one stage per edge; the oldest retires at stage LV.
    task automatic model_edge(input bit v, input logic [63:0] d, input bit c,
                              input bit ov, input bit sf, input bit fl);
        op_t op;
        if (pipe.size() > 0 && pipe[0].stage == LV) begin
            if (pipe[0].sf) m_flags = {pipe[0].n, pipe[0].zero, pipe[0].c, pipe[0].v};
            void'(pipe.pop_front());
        end
        if (fl) begin
            pipe.delete();
        end else begin
            foreach (pipe[i]) pipe[i].stage = pipe[i].stage + 1;
            if (v) begin
                op.zero  = (d == 64'd0);
                op.n     = d[63];
                op.c     = c;
                op.v     = ov;
                op.sf    = sf;
                op.stage = 1;
                pipe.push_back(op);
            end
        end
    endtask

    task automatic cycle(input bit v, input logic [63:0] d, input bit c,
                         input bit ov, input bit sf, input bit fl);
        @(negedge clk);
        check_outputs();
        in_valid     = v;
        in_data      = d;
        in_carry     = c;
        in_overflow  = ov;
        in_set_flags = sf;
        flush        = fl;
        model_edge(v, d, c, ov, sf, fl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        int          sel;

        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_result_zero", result_zero, 1'b0);
        check_eq("rst_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b0000);
        check_eq("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero result with carry: NZCV becomes 0110
        cycle(1'b1, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(4);
        check_eq("nzcv_zero_op", {flag_n, flag_z, flag_c, flag_v}, 4'b0110);

        // Stream LSB, zero, MSB
        cycle(1'b1, 64'h1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        check_eq("nzcv_stream", {flag_n, flag_z, flag_c, flag_v}, 4'b1000);

        // Non-flag-setting zero op leaves NZCV alone
        cycle(1'b1, 64'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(5);
        check_eq("nzcv_hold", {flag_n, flag_z, flag_c, flag_v}, 4'b1000);

        // Flush one edge after the third issue: only the first completes
        cycle(1'b1, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 64'h5, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);
        check_eq("nzcv_flush", {flag_n, flag_z, flag_c, flag_v}, 4'b0101);

        // WIDTH=13: padded top group and zero result
        @(negedge clk);
        v13 = 1'b1; d13 = 13'h1000; sf13 = 1'b1;
        @(negedge clk);
        check_eq("w13_ov_e0", ov13, 1'b0);
        d13 = 13'h0000;
        @(negedge clk);
        check_eq("w13_ov_op1", ov13, 1'b1);
        check_eq("w13_rz_op1", rz13, 1'b0);
        v13 = 1'b0; sf13 = 1'b0;
        @(negedge clk);
        check_eq("w13_ov_op2", ov13, 1'b1);
        check_eq("w13_rz_op2", rz13, 1'b1);
        check_eq("w13_nzcv_op1", {n13, z13, c13, vv13}, 4'b1000);
        @(negedge clk);
        check_eq("w13_ov_done", ov13, 1'b0);
        check_eq("w13_nzcv_op2", {n13, z13, c13, vv13}, 4'b0100);
        check_eq("w13_busy", busy13, 1'b0);

        // Random stream
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0:       d = 64'd0;
                1:       d = '1;
                2:       d = 64'd1 << $urandom_range(0, 63);
                3:       d = {$urandom, $urandom};
                default: d = 64'h8000_0000_0000_0000;
            endcase
            cycle($urandom_range(0, 3) != 0, d, 1'($urandom), 1'($urandom),
                  1'($urandom), $urandom_range(0, 9) == 0);
        end
        idle(5);

        // Asynchronous reset with two ops in flight
        cycle(1'b1, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 64'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid, 1'b0);
        check_eq("arst_result_zero", result_zero, 1'b0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b0000);
        pipe.delete();
        m_flags = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
